// File: rtl/ff_pkg.sv
// Shared encodings for the multimode flip-flop bank: operating modes and
// the action taken on an SR illegal input (S=R=1).
package ff_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;
    localparam int POL_TOG  = 3;

endpackage

// File: rtl/ff_next_bit.sv
// Combinational next-state and SR-conflict function for one bank bit.
module ff_next_bit
    import ff_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  mode_e mode,
    input  logic  en,
    input  logic  a,
    input  logic  b,
    input  logic  q,
    output logic  q_nxt,
    output logic  conflict
);

    always_comb begin
        q_nxt    = q;
        conflict = 1'b0;
        if (en) begin
            case (mode)
                MODE_SR: begin
                    case ({a, b})
                        2'b01:   q_nxt = 1'b0;
                        2'b10:   q_nxt = 1'b1;
                        2'b11: begin
                            conflict = 1'b1;
                            case (SR_POLICY)
                                POL_SET: q_nxt = 1'b1;
                                POL_RST: q_nxt = 1'b0;
                                POL_TOG: q_nxt = ~q;
                                default: q_nxt = q;
                            endcase
                        end
                        default: q_nxt = q;
                    endcase
                end
                MODE_JK: begin
                    case ({a, b})
                        2'b01:   q_nxt = 1'b0;
                        2'b10:   q_nxt = 1'b1;
                        2'b11:   q_nxt = ~q;
                        default: q_nxt = q;
                    endcase
                end
                MODE_D:  q_nxt = a;
                MODE_T:  q_nxt = a ? ~q : q;
                default: q_nxt = q;
            endcase
        end
    end

endmodule

// File: rtl/multimode_ff_bank.sv
// WIDTH-bit register bank; every bit acts as an SR/JK/D/T flip-flop chosen
// by a shared mode register, with sticky SR-conflict flags and a counter.
module multimode_ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               SR_POLICY = POL_HOLD,
    parameter int               CNT_W     = 8,
    parameter logic [WIDTH-1:0] RST_VAL   = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_ld,
    input  logic [1:0]       mode_in,
    input  logic [WIDTH-1:0] en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             conflict_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] changed,
    output logic [WIDTH-1:0] conflict,
    output logic [CNT_W-1:0] conflict_cnt,
    output logic [1:0]       mode
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    mode_e            mode_r;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] conf_vec;
    logic             conf_any;

    assign mode     = mode_r;
    assign conf_any = |conf_vec;

    // A mode-load cycle freezes every bit and suppresses detection,
    // so it is folded into the per-bit enable.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        ff_next_bit #(
            .SR_POLICY(SR_POLICY)
        ) u_bit (
            .mode    (mode_r),
            .en      (en[i] & ~mode_ld),
            .a       (a[i]),
            .b       (b[i]),
            .q       (q[i]),
            .q_nxt   (q_nxt[i]),
            .conflict(conf_vec[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q            <= RST_VAL;
            qn           <= ~RST_VAL;
            changed      <= '0;
            conflict     <= '0;
            conflict_cnt <= '0;
            mode_r       <= MODE_SR;
        end else begin
            q       <= q_nxt;
            qn      <= ~q_nxt;
            changed <= q_nxt ^ q;
            if (mode_ld)
                mode_r <= mode_e'(mode_in);
            // A fresh conflict in the clearing cycle survives the clear.
            if (conflict_clr) begin
                conflict     <= conf_vec;
                conflict_cnt <= conf_any ? CNT_ONE : '0;
            end else begin
                conflict <= conflict | conf_vec;
                if (conf_any && conflict_cnt != CNT_MAX)
                    conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_multimode_ff_bank.sv
// Directed scoreboard bench: the driver queues hand-computed results, a
// monitor pops and compares them one cycle after each edge.
module tb_multimode_ff_bank;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_ld = 1'b0;
    logic [1:0] mode_in = 2'b00;
    logic [7:0] en = '0, a = '0, b = '0;
    logic       conflict_clr = 1'b0;
    logic [7:0] q, qn, changed, conflict;
    logic [1:0] conflict_cnt, mode;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] qn;
        logic [7:0] chg;
        logic [7:0] conf;
        logic [1:0] cnt;
        logic [1:0] mode;
        string      tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    multimode_ff_bank #(
        .WIDTH    (8),
        .SR_POLICY(0),
        .CNT_W    (2),
        .RST_VAL  (8'hA5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_ld     (mode_ld),
        .mode_in     (mode_in),
        .en          (en),
        .a           (a),
        .b           (b),
        .conflict_clr(conflict_clr),
        .q           (q),
        .qn          (qn),
        .changed     (changed),
        .conflict    (conflict),
        .conflict_cnt(conflict_cnt),
        .mode        (mode)
    );

    task automatic chk(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic ml, input logic [1:0] mi,
                        input logic [7:0] ev, input logic [7:0] av, input logic [7:0] bv,
                        input logic clr, input logic [7:0] xq, input logic [7:0] xchg,
                        input logic [7:0] xconf, input logic [1:0] xcnt, input logic [1:0] xmode);
        exp_t e;
        @(negedge clk);
        rst = r; mode_ld = ml; mode_in = mi; en = ev; a = av; b = bv; conflict_clr = clr;
        e.q = xq; e.qn = ~xq; e.chg = xchg; e.conf = xconf; e.cnt = xcnt; e.mode = xmode; e.tag = tag;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.tag, "q",    q,                  e.q);
                chk(e.tag, "qn",   qn,                 e.qn);
                chk(e.tag, "chg",  changed,            e.chg);
                chk(e.tag, "conf", conflict,           e.conf);
                chk(e.tag, "cnt",  {6'b0, conflict_cnt}, {6'b0, e.cnt});
                chk(e.tag, "mode", {6'b0, mode},       {6'b0, e.mode});
            end
        end
    end

    initial begin : driver
        //    tag          rst ml  mi     en     a      b      clr  q      chg    conf   cnt    mode
        step("reset",      1, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0, 8'hA5, 8'h00, 8'h00, 2'd0, 2'd0);
        step("sr_set_rst", 0, 0, 2'd0, 8'hFF, 8'h0F, 8'hF0, 0, 8'h0F, 8'hAA, 8'h00, 2'd0, 2'd0);
        step("sr_hold",    0, 0, 2'd0, 8'hFF, 8'h00, 8'h00, 0, 8'h0F, 8'h00, 8'h00, 2'd0, 2'd0);
        step("conf1",      0, 0, 2'd0, 8'h01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd1, 2'd0);
        step("conf2",      0, 0, 2'd0, 8'h01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd2, 2'd0);
        step("conf3",      0, 0, 2'd0, 8'h01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd3, 2'd0);
        step("conf_sat4",  0, 0, 2'd0, 8'h01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd3, 2'd0);
        step("conf_sat5",  0, 0, 2'd0, 8'h01, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd3, 2'd0);
        step("ld_t",       0, 1, 2'd3, 8'hFF, 8'hFF, 8'hFF, 0, 8'h0F, 8'h00, 8'h01, 2'd3, 2'd3);
        step("t_toggle",   0, 0, 2'd0, 8'hFF, 8'h3C, 8'h00, 0, 8'h33, 8'h3C, 8'h01, 2'd3, 2'd3);
        step("ld_d",       0, 1, 2'd2, 8'hFF, 8'hFF, 8'h00, 0, 8'h33, 8'h00, 8'h01, 2'd3, 2'd2);
        step("d_load",     0, 0, 2'd0, 8'hFF, 8'h81, 8'h00, 0, 8'h81, 8'hB2, 8'h01, 2'd3, 2'd2);
        step("clr_alone",  0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 1, 8'h81, 8'h00, 8'h00, 2'd0, 2'd2);
        step("ld_sr",      0, 1, 2'd0, 8'h00, 8'h00, 8'h00, 0, 8'h81, 8'h00, 8'h00, 2'd0, 2'd0);
        step("dis_ab11",   0, 0, 2'd0, 8'h00, 8'hFF, 8'hFF, 0, 8'h81, 8'h00, 8'h00, 2'd0, 2'd0);
        step("conf_bit0",  0, 0, 2'd0, 8'h01, 8'h01, 8'h01, 0, 8'h81, 8'h00, 8'h01, 2'd1, 2'd0);
        step("clr_new7",   0, 0, 2'd0, 8'h80, 8'h80, 8'h80, 1, 8'h81, 8'h00, 8'h80, 2'd1, 2'd0);
        step("ld_jk",      0, 1, 2'd1, 8'hFF, 8'hFF, 8'hFF, 0, 8'h81, 8'h00, 8'h80, 2'd1, 2'd1);
        step("jk_mix",     0, 0, 2'd0, 8'hFF, 8'hF0, 8'hCC, 0, 8'h71, 8'hF0, 8'h80, 2'd1, 2'd1);
        step("ld_t2",      0, 1, 2'd3, 8'hFF, 8'hFF, 8'h00, 0, 8'h71, 8'h00, 8'h80, 2'd1, 2'd3);
        step("t_stream1",  0, 0, 2'd0, 8'hFF, 8'hFF, 8'h00, 0, 8'h8E, 8'hFF, 8'h80, 2'd1, 2'd3);
        step("t_stream2",  0, 0, 2'd0, 8'hFF, 8'hFF, 8'h00, 0, 8'h71, 8'hFF, 8'h80, 2'd1, 2'd3);
        step("rst_mid",    1, 0, 2'd0, 8'hFF, 8'hFF, 8'h00, 0, 8'hA5, 8'h00, 8'h00, 2'd0, 2'd0);
        step("post_rst_sr",0, 0, 2'd0, 8'hFF, 8'hFF, 8'h00, 0, 8'hFF, 8'h5A, 8'h00, 2'd0, 2'd0);
        @(negedge clk);
        rst = 0; mode_ld = 0; en = '0; a = '0; b = '0; conflict_clr = 0;
        repeat (4) @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain pending=%0d required=0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #20000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
